// File: rtl/alignment_initiator.sv
// alignment_initiator
//   Transmit side of a valid/accept write link. Write requests pushed by a
//   local producer are queued in a small circular FIFO and presented one at a
//   time through an output register to the receiving block.
//
//   Handshake: once valid rises, valid/data_out/addr_out are frozen until the
//   cycle in which accept is also high (the transfer cycle). accept while
//   valid is low has no effect. The producer side is a push interface: an
//   entry is taken when push_valid && push_ready; a push while push_ready is
//   low is dropped and recorded in the sticky overflow flag.
//
// Ports
//   clk, res_n      clock (rising edge), asynchronous active-low reset
//   push_valid      producer offers {push_addr, push_data} this cycle
//   push_ready      FIFO not full
//   valid           request presented to the receiver
//   data_out        request data  (to receiver data_in)
//   addr_out        request address (to receiver addr)
//   accept          receiver takes the request when high together with valid
//   level           entries held: FIFO plus output register (0..DEPTH+1)
//   overflow        sticky: push attempted while push_ready was low
//   stall_timeout   sticky: request stalled STALL_LIMIT consecutive cycles
//   clear_err       synchronous clear of both sticky flags (set wins)
module alignment_initiator #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 4,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int STALL_LIMIT     = 15
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic                       push_valid,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic [ADDR_WIDTH-1:0]      push_addr,
    output logic                       push_ready,
    output logic                       valid,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [ADDR_WIDTH-1:0]      addr_out,
    input  logic                       accept,
    output logic [FIFO_DEPTH_LOG2:0]   level,
    output logic                       overflow,
    output logic                       stall_timeout,
    input  logic                       clear_err
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CNT_W = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_LIMIT);

    // FIFO storage and pointers; the extra MSB on each pointer separates
    // full (MSBs differ, index bits equal) from empty (pointers equal).
    logic [DATA_WIDTH-1:0]    mem_data [DEPTH];
    logic [ADDR_WIDTH-1:0]    mem_addr [DEPTH];
    logic [FIFO_DEPTH_LOG2:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2:0] rd_ptr;
    logic                     fifo_empty;
    logic                     fifo_full;

    logic                     push_acc;
    logic                     xfer;
    logic                     out_free;
    logic                     pop;
    logic                     bypass;
    logic                     fifo_wr;

    logic [CNT_W-1:0]         stall_cnt;
    logic [CNT_W-1:0]         stall_cnt_inc;
    logic                     stalled;
    logic                     stall_set;
    logic                     ovf_set;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                        (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);

    assign push_ready = !fifo_full;
    assign push_acc   = push_valid && push_ready;
    assign ovf_set    = push_valid && !push_ready;
    assign xfer       = valid && accept;

    // The output register can take a new entry when it is empty or is being
    // emptied by a transfer this cycle. The FIFO head always has priority so
    // order is kept; a push only bypasses the FIFO when nothing is queued.
    assign out_free = !valid || xfer;
    assign pop      = out_free && !fifo_empty;
    assign bypass   = out_free && fifo_empty && push_acc;
    assign fifo_wr  = push_acc && !bypass;

    // FIFO storage needs no reset; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_data[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= push_data;
            mem_addr[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= push_addr;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Output register. When it goes idle the old data is simply left in
    // place; only valid carries meaning then.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            valid    <= 1'b0;
            data_out <= '0;
            addr_out <= '0;
        end else if (out_free) begin
            if (pop) begin
                valid    <= 1'b1;
                data_out <= mem_data[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
                addr_out <= mem_addr[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
            end else if (bypass) begin
                valid    <= 1'b1;
                data_out <= push_data;
                addr_out <= push_addr;
            end else begin
                valid    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            level <= '0;
        end else begin
            case ({push_acc, xfer})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Stall counter saturates at the limit; the flag is set on every stalled
    // cycle at the limit, so a clear while still stalled does not stick.
    assign stalled       = valid && !accept;
    assign stall_cnt_inc = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 1'b1;
    assign stall_set     = stalled && (stall_cnt_inc == STALL_MAX);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            stall_cnt <= '0;
        end else if (stalled) begin
            stall_cnt <= stall_cnt_inc;
        end else begin
            stall_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            overflow      <= 1'b0;
            stall_timeout <= 1'b0;
        end else begin
            overflow      <= ovf_set   || (overflow      && !clear_err);
            stall_timeout <= stall_set || (stall_timeout && !clear_err);
        end
    end

endmodule

// File: tb/tb_alignment_initiator.sv
// Testbench for alignment_initiator: table-driven vectors plus hand-written
// multi-cycle sequences, with a negedge monitor holding a reference model
// and a scoreboard queue of expected transfers.
module tb_alignment_initiator;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int LOG2  = 2;
    localparam int DEPTH = 1 << LOG2;
    localparam int LIMIT = 15;

    logic            clk;
    logic            res_n;
    logic            push_valid;
    logic [DW-1:0]   push_data;
    logic [AW-1:0]   push_addr;
    logic            push_ready;
    logic            valid;
    logic [DW-1:0]   data_out;
    logic [AW-1:0]   addr_out;
    logic            accept;
    logic [LOG2:0]   level;
    logic            overflow;
    logic            stall_timeout;
    logic            clear_err;

    int errors = 0;
    int checks = 0;

    alignment_initiator #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH_LOG2(LOG2), .STALL_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .res_n(res_n),
        .push_valid(push_valid), .push_data(push_data), .push_addr(push_addr),
        .push_ready(push_ready),
        .valid(valid), .data_out(data_out), .addr_out(addr_out), .accept(accept),
        .level(level), .overflow(overflow), .stall_timeout(stall_timeout),
        .clear_err(clear_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic pv, input logic [DW-1:0] d, input logic [AW-1:0] a,
                         input logic acc, input logic clr);
        push_valid = pv;
        push_data  = d;
        push_addr  = a;
        accept     = acc;
        clear_err  = clr;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    // Reference model: every held entry is either presented or queued, so
    // valid is simply "anything held" and push_ready is "queue below DEPTH",
    // i.e. total held <= DEPTH.
    logic [AW+DW-1:0] exp_q[$];
    int               m_level;
    int               m_cnt;
    logic             m_ovf;
    logic             m_stall;
    logic             prev_hold;
    logic [AW+DW-1:0] prev_word;

    always @(negedge clk) begin
        logic             m_ready;
        logic             pacc;
        logic             xf;
        logic             st_set;
        logic [AW+DW-1:0] got;
        logic [AW+DW-1:0] exp;
        if (!res_n) begin
            m_level   = 0;
            m_cnt     = 0;
            m_ovf     = 1'b0;
            m_stall   = 1'b0;
            prev_hold = 1'b0;
            prev_word = '0;
            exp_q.delete();
        end else begin
            m_ready = (m_level <= DEPTH);
            check("mon_level", 32'(level), 32'(m_level));
            check("mon_valid", 32'(valid), 32'(m_level > 0));
            check("mon_push_ready", 32'(push_ready), 32'(m_ready));
            check("mon_overflow", 32'(overflow), 32'(m_ovf));
            check("mon_stall", 32'(stall_timeout), 32'(m_stall));

            if (prev_hold) begin
                check("hold_valid", 32'(valid), 32'd1);
                check("hold_word", 32'({addr_out, data_out}), 32'(prev_word));
            end

            if (valid && accept) begin
                got = {addr_out, data_out};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_unexpected actual=%0h required=none", got);
                end else begin
                    exp = exp_q.pop_front();
                    check("xfer_order", 32'(got), 32'(exp));
                end
            end

            prev_hold = valid && !accept;
            prev_word = {addr_out, data_out};

            // Predict the state after the next rising edge.
            pacc = push_valid && m_ready;
            xf   = (m_level > 0) && accept;
            if (pacc) exp_q.push_back({push_addr, push_data});
            st_set = 1'b0;
            if ((m_level > 0) && !accept) begin
                if (m_cnt < LIMIT) m_cnt = m_cnt + 1;
                if (m_cnt == LIMIT) st_set = 1'b1;
            end else begin
                m_cnt = 0;
            end
            m_stall = st_set || (m_stall && !clear_err);
            m_ovf   = (push_valid && !m_ready) || (m_ovf && !clear_err);
            m_level = m_level + (pacc ? 1 : 0) - (xf ? 1 : 0);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic          pv;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          acc;
        logic          clr;
        logic [LOG2:0] e_level;
        logic          e_valid;
        logic          e_ready;
        logic          e_ovf;
        logic          e_stall;
        logic          chk_word;
        logic [DW-1:0] e_d;
        logic [AW-1:0] e_a;
    } vec_t;

    function automatic vec_t mk(input logic pv, input logic [DW-1:0] d, input logic [AW-1:0] a,
                                input logic acc, input logic clr, input logic [LOG2:0] e_level,
                                input logic e_valid, input logic e_ready, input logic e_ovf,
                                input logic e_stall, input logic chk_word,
                                input logic [DW-1:0] e_d, input logic [AW-1:0] e_a);
        vec_t v;
        v.pv = pv; v.d = d; v.a = a; v.acc = acc; v.clr = clr;
        v.e_level = e_level; v.e_valid = e_valid; v.e_ready = e_ready;
        v.e_ovf = e_ovf; v.e_stall = e_stall;
        v.chk_word = chk_word; v.e_d = e_d; v.e_a = e_a;
        return v;
    endfunction

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    // ---------------- main sequence ----------------
    initial begin
        int vcnt;
        int rlow;

        // Single push, then accept=0 fill to overflow, drain, clear.
        vecs[0]  = mk(1'b1, 8'hA5, 4'h3, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 4'h3);
        vecs[1]  = mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        vecs[2]  = mk(1'b1, 8'h10, 4'h1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 4'h1);
        vecs[3]  = mk(1'b1, 8'h11, 4'h2, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 4'h1);
        vecs[4]  = mk(1'b1, 8'h12, 4'h3, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 4'h1);
        vecs[5]  = mk(1'b1, 8'h13, 4'h4, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 4'h1);
        vecs[6]  = mk(1'b1, 8'h14, 4'h5, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 4'h1);
        vecs[7]  = mk(1'b1, 8'h15, 4'h6, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 4'h1);
        vecs[8]  = mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 4'h2);
        vecs[9]  = mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 4'h3);
        vecs[10] = mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h13, 4'h4);
        vecs[11] = mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h14, 4'h5);
        vecs[12] = mk(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
        vecs[13] = mk(1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);

        // Reset
        res_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 res_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_valid", 32'(valid), 32'd0);
            check("idle_level", 32'(level), 32'd0);
            check("idle_ready", 32'(push_ready), 32'd1);
            check("idle_flags", 32'({overflow, stall_timeout}), 32'd0);
            check("idle_word", 32'({addr_out, data_out}), 32'd0);
        end

        // Table
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].pv, vecs[i].d, vecs[i].a, vecs[i].acc, vecs[i].clr);
            tick();
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_level));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_ready", i), 32'(push_ready), 32'(vecs[i].e_ready));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
            check($sformatf("vec%0d_stall", i), 32'(stall_timeout), 32'(vecs[i].e_stall));
            if (vecs[i].chk_word)
                check($sformatf("vec%0d_word", i), 32'({addr_out, data_out}),
                      32'({vecs[i].e_a, vecs[i].e_d}));
        end

        // Back-to-back pushes with accept held high
        vcnt = 0;
        rlow = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, 8'(i), 4'(i), 1'b1, 1'b0);
            else       drive(1'b0, '0, '0, 1'b1, 1'b0);
            tick();
            if (valid) vcnt++;
            if (!push_ready) rlow++;
        end
        check("b2b_valid_cycles", 32'(vcnt), 32'd8);
        check("b2b_ready_low", 32'(rlow), 32'd0);
        check("b2b_level", 32'(level), 32'd0);

        // Receiver stall with one entry presented
        drive(1'b1, 8'h5C, 4'h9, 1'b0, 1'b0);
        tick();
        check("stall_valid", 32'(valid), 32'd1);
        check("stall_flag_k0", 32'(stall_timeout), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            tick();
            check($sformatf("stall_flag_k%0d", k), 32'(stall_timeout), 32'(k >= LIMIT));
            check("stall_word", 32'({addr_out, data_out}), 32'({4'h9, 8'h5C}));
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        check("stall_xfer_valid", 32'(valid), 32'd0);
        check("stall_flag_kept", 32'(stall_timeout), 32'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        check("stall_flag_cleared", 32'(stall_timeout), 32'd0);

        // Alternate accept while pushing every cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                  (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            tick();
        end
        check("alt_level", 32'(level), 32'd5);
        check("alt_ovf", 32'(overflow), 32'd0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (6) tick();
        check("alt_drained", 32'(level), 32'd0);

        // Random traffic; model and scoreboard do the checking
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0));
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b1);
        repeat (8) tick();
        check("rand_drained", 32'(level), 32'd0);
        check("rand_flags_cleared", 32'({overflow, stall_timeout}), 32'd0);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a stalled transfer
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 4'(i), 1'b0, 1'b0);
            tick();
        end
        check("pre_reset_level", 32'(level), 32'd3);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        res_n = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_word", 32'({addr_out, data_out}), 32'd0);
        check("rst_flags", 32'({overflow, stall_timeout}), 32'd0);
        repeat (2) @(posedge clk);
        #1 res_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(push_ready), 32'd1);
        drive(1'b1, 8'h77, 4'h7, 1'b1, 1'b0);
        tick();
        check("post_rst_word", 32'({valid, addr_out, data_out}), 32'({1'b1, 4'h7, 8'h77}));
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        check("post_rst_idle", 32'(valid), 32'd0);
        tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
